sim_mcb_user_port: RTL and testbench

- Parametrised behavioural model of one MCB user port (cmd/wr/rd FIFOs) with a real backing memory.
- Replaces the stubbed p0–p3 port models in the DDR3 wishbone bench, so written data reads back correctly.
- Provides configurable data width, memory depth and read latency.
- Underrun, overflow and error flags follow MCB semantics.
- Optional deterministic stall injection.

---
 rtl/sim_mcb_pkg.sv | 34 +++
 rtl/sim_mcb_sync_fifo.sv | 86 ++++++++
 rtl/sim_mcb_user_port.sv | 254 +++++++++++++++++++++++++
 tb/tb_sim_mcb_user_port.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/sim_mcb_pkg.sv
// Shared definitions for the behavioural MCB user-port model: command encodings,
// executor states, command record and the stall LFSR step.
package sim_mcb_pkg;

    localparam int FIFO_DEPTH = 64;
    localparam int COUNT_W    = 7;

    localparam logic [2:0] CMD_WRITE    = 3'b000;
    localparam logic [2:0] CMD_READ     = 3'b001;
    localparam logic [2:0] CMD_WRITE_PC = 3'b010;
    localparam logic [2:0] CMD_READ_PC  = 3'b011;
    localparam logic [2:0] CMD_REFRESH  = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WRITE   = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_READ    = 3'd3,
        ST_REFRESH = 3'd4,
        ST_NOP     = 3'd5
    } exec_state_e;

    typedef struct packed {
        logic [2:0]  instr;
        logic [5:0]  bl;
        logic [29:0] byte_addr;
    } cmd_t;

    // Fibonacci LFSR, taps 16,14,13,11
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

endpackage

// File: rtl/sim_mcb_sync_fifo.sv
// Synchronous FIFO with registered full/empty/count and a first-word
// fall-through head that reads as zero while the FIFO is empty.
module sim_mcb_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d, empty_q, empty_d;
    logic             do_push_s, do_pop_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
    endfunction

    // Pointer, occupancy and flag next-state
    always_comb begin
        do_push_s = push && !full_q;
        do_pop_s  = pop && !empty_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (do_push_s) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == {CNT_W{1'b0}});
    end

    // Control state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Entry storage; contents need no reset because the pointers gate them
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = empty_q ? {WIDTH{1'b0}} : mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;
    assign count = count_q;

endmodule

// File: rtl/sim_mcb_user_port.sv
// Behavioural model of one MCB user port backed by a real memory.
// Define SIM_MCB_STALL_INJECT_EN to enable LFSR-driven wr_full / read stalls.
module sim_mcb_user_port
    import sim_mcb_pkg::*;
#(
    parameter int          DATA_WIDTH     = 32,
    parameter int          MEM_WORDS_LOG2 = 12,
    parameter int          CMD_DEPTH      = 4,
    parameter int          READ_LATENCY   = 8,
    parameter int          REFRESH_CYCLES = 16,
    parameter int          CAL_CYCLES     = 32,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1,
    localparam int         MASK_WIDTH     = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  calibration_done,
    input  logic                  cmd_en,
    input  logic [2:0]            cmd_instr,
    input  logic [5:0]            cmd_bl,
    input  logic [29:0]           cmd_byte_addr,
    output logic                  cmd_empty,
    output logic                  cmd_full,
    input  logic                  wr_en,
    input  logic [MASK_WIDTH-1:0] wr_mask,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_full,
    output logic                  wr_empty,
    output logic [COUNT_W-1:0]    wr_count,
    output logic                  wr_underrun,
    output logic                  wr_error,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_full,
    output logic                  rd_empty,
    output logic [COUNT_W-1:0]    rd_count,
    output logic                  rd_overflow,
    output logic                  rd_error
);

    localparam int BYTE_SHIFT = $clog2(MASK_WIDTH);
    localparam int MEM_WORDS  = 1 << MEM_WORDS_LOG2;
    localparam int CAL_W      = $clog2(CAL_CYCLES + 1);
    localparam int CMD_CNT_W  = $clog2(CMD_DEPTH + 1);
    localparam int TMR_W      = 16;
    localparam int WR_W       = DATA_WIDTH + MASK_WIDTH;

    cmd_t                      cmd_in_s, cmd_head_s;
    logic                      cmd_pop_s;
    logic [CMD_CNT_W-1:0]      cmd_count_s;
    logic [WR_W-1:0]           wr_head_s;
    logic                      wr_pop_s, wr_full_true_s, wr_empty_s;
    logic                      rd_push_s, rd_full_s, rd_empty_s;
    logic                      mem_we_s, underrun_evt_s, overflow_evt_s;
    logic                      wr_stall_s, rd_hold_s;

    exec_state_e               state_q, state_d;
    logic [MEM_WORDS_LOG2-1:0] addr_q, addr_d;
    logic [6:0]                remain_q, remain_d;
    logic [TMR_W-1:0]          timer_q, timer_d;
    logic [CAL_W-1:0]          cal_cnt_q, cal_cnt_d;
    logic                      cal_done_q, cal_done_d;
    logic                      wr_underrun_q, wr_underrun_d, wr_error_q, wr_error_d;
    logic                      rd_overflow_q, rd_overflow_d, rd_error_q, rd_error_d;

    logic [DATA_WIDTH-1:0]     mem_q [MEM_WORDS];

    assign cmd_in_s = '{instr: cmd_instr, bl: cmd_bl, byte_addr: cmd_byte_addr};

    sim_mcb_sync_fifo #(.WIDTH($bits(cmd_t)), .DEPTH(CMD_DEPTH), .CNT_W(CMD_CNT_W)) u_cmd_fifo (
        .clk(clk), .rst_n(rst_n), .push(cmd_en), .pop(cmd_pop_s), .din(cmd_in_s),
        .dout(cmd_head_s), .full(cmd_full), .empty(cmd_empty), .count(cmd_count_s)
    );

    sim_mcb_sync_fifo #(.WIDTH(WR_W), .DEPTH(FIFO_DEPTH), .CNT_W(COUNT_W)) u_wr_fifo (
        .clk(clk), .rst_n(rst_n), .push(wr_en), .pop(wr_pop_s), .din({wr_mask, wr_data}),
        .dout(wr_head_s), .full(wr_full_true_s), .empty(wr_empty_s), .count(wr_count)
    );

    sim_mcb_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH), .CNT_W(COUNT_W)) u_rd_fifo (
        .clk(clk), .rst_n(rst_n), .push(rd_push_s), .pop(rd_en), .din(mem_q[addr_q]),
        .dout(rd_data), .full(rd_full_s), .empty(rd_empty_s), .count(rd_count)
    );

`ifdef SIM_MCB_STALL_INJECT_EN
    logic [15:0] lfsr_q;

    // Free-running stall LFSR
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    assign wr_stall_s = (lfsr_q[3:0] < 4'd3);
    assign rd_hold_s  = (lfsr_q[7:4] < 4'd3);
`else
    assign wr_stall_s = 1'b0;
    assign rd_hold_s  = 1'b0;
`endif

    // Calibration counter and sticky error flags
    always_comb begin
        if (cal_done_q) begin
            cal_cnt_d  = cal_cnt_q;
            cal_done_d = 1'b1;
        end else begin
            cal_cnt_d  = cal_cnt_q + CAL_W'(1);
            cal_done_d = (cal_cnt_q == CAL_W'(CAL_CYCLES - 1));
        end
        wr_underrun_d = wr_underrun_q | underrun_evt_s;
        wr_error_d    = wr_error_q | underrun_evt_s | (wr_en & wr_full_true_s);
        rd_overflow_d = rd_overflow_q | overflow_evt_s;
        rd_error_d    = rd_error_q | overflow_evt_s | (rd_en & rd_empty_s);
    end

    // Executor next-state and datapath strobes
    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        remain_d       = remain_q;
        timer_d        = timer_q;
        cmd_pop_s      = 1'b0;
        wr_pop_s       = 1'b0;
        rd_push_s      = 1'b0;
        mem_we_s       = 1'b0;
        underrun_evt_s = 1'b0;
        overflow_evt_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cal_done_q && (cmd_count_s != {CMD_CNT_W{1'b0}})) begin
                    cmd_pop_s = 1'b1;
                    addr_d    = MEM_WORDS_LOG2'(cmd_head_s.byte_addr >> BYTE_SHIFT);
                    remain_d  = 7'(cmd_head_s.bl) + 7'd1;
                    case (cmd_head_s.instr)
                        CMD_WRITE, CMD_WRITE_PC: state_d = ST_WRITE;
                        CMD_READ, CMD_READ_PC: begin
                            if (READ_LATENCY > 1) begin
                                state_d = ST_RD_WAIT;
                                timer_d = TMR_W'(READ_LATENCY - 1);
                            end else begin
                                state_d = ST_READ;
                            end
                        end
                        CMD_REFRESH: begin
                            state_d = ST_REFRESH;
                            timer_d = TMR_W'(REFRESH_CYCLES);
                        end
                        default: state_d = ST_NOP;
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (!wr_empty_s) begin
                    wr_pop_s = 1'b1;
                    mem_we_s = 1'b1;
                end else begin
                    underrun_evt_s = 1'b1;
                end
                addr_d   = addr_q + MEM_WORDS_LOG2'(1);
                remain_d = remain_q - 7'd1;
                if (remain_q == 7'd1) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_RD_WAIT: begin
                if (timer_q <= TMR_W'(1)) begin
                    state_d = ST_READ;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            ST_READ: begin
                if (rd_hold_s) begin
                    state_d = ST_READ;
                end else begin
                    rd_push_s      = 1'b1;
                    overflow_evt_s = rd_full_s;
                    addr_d         = addr_q + MEM_WORDS_LOG2'(1);
                    remain_d       = remain_q - 7'd1;
                    if (remain_q == 7'd1) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_REFRESH: begin
                if (timer_q <= TMR_W'(1)) begin
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            ST_NOP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Executor, calibration and flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            addr_q        <= {MEM_WORDS_LOG2{1'b0}};
            remain_q      <= 7'd0;
            timer_q       <= {TMR_W{1'b0}};
            cal_cnt_q     <= {CAL_W{1'b0}};
            cal_done_q    <= 1'b0;
            wr_underrun_q <= 1'b0;
            wr_error_q    <= 1'b0;
            rd_overflow_q <= 1'b0;
            rd_error_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            remain_q      <= remain_d;
            timer_q       <= timer_d;
            cal_cnt_q     <= cal_cnt_d;
            cal_done_q    <= cal_done_d;
            wr_underrun_q <= wr_underrun_d;
            wr_error_q    <= wr_error_d;
            rd_overflow_q <= rd_overflow_d;
            rd_error_q    <= rd_error_d;
        end
    end

    // Backing memory; a set mask bit keeps the old byte
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            for (int b = 0; b < MASK_WIDTH; b++) begin
                if (!wr_head_s[DATA_WIDTH + b]) begin
                    mem_q[addr_q][b*8 +: 8] <= wr_head_s[b*8 +: 8];
                end
            end
        end
    end

    assign calibration_done = cal_done_q;
    assign wr_full          = wr_full_true_s | wr_stall_s;
    assign wr_empty         = wr_empty_s;
    assign wr_underrun      = wr_underrun_q;
    assign wr_error         = wr_error_q;
    assign rd_full          = rd_full_s;
    assign rd_empty         = rd_empty_s;
    assign rd_overflow      = rd_overflow_q;
    assign rd_error         = rd_error_q;

endmodule

// File: tb/tb_sim_mcb_user_port.sv
// Scoreboard bench for sim_mcb_user_port: expected read words are queued at
// command issue and a separate monitor pops and compares rd_data.
module tb_sim_mcb_user_port;

    localparam logic [2:0] I_WR  = 3'b000;
    localparam logic [2:0] I_RD  = 3'b001;
    localparam logic [2:0] I_REF = 3'b100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        calibration_done;
    logic        cmd_en;
    logic [2:0]  cmd_instr;
    logic [5:0]  cmd_bl;
    logic [29:0] cmd_byte_addr;
    logic        cmd_empty, cmd_full;
    logic        wr_en;
    logic [3:0]  wr_mask;
    logic [31:0] wr_data;
    logic        wr_full, wr_empty;
    logic [6:0]  wr_count;
    logic        wr_underrun, wr_error;
    logic        rd_en;
    logic [31:0] rd_data;
    logic        rd_full, rd_empty;
    logic [6:0]  rd_count;
    logic        rd_overflow, rd_error;

    logic        mon_rd_en = 1'b0;
    logic        stim_rd_en;
    logic        drain_en;
    logic [31:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;

    assign rd_en = mon_rd_en | stim_rd_en;

    always #5 clk = ~clk;

    sim_mcb_user_port dut (
        .clk(clk), .rst_n(rst_n), .calibration_done(calibration_done),
        .cmd_en(cmd_en), .cmd_instr(cmd_instr), .cmd_bl(cmd_bl),
        .cmd_byte_addr(cmd_byte_addr), .cmd_empty(cmd_empty), .cmd_full(cmd_full),
        .wr_en(wr_en), .wr_mask(wr_mask), .wr_data(wr_data), .wr_full(wr_full),
        .wr_empty(wr_empty), .wr_count(wr_count), .wr_underrun(wr_underrun),
        .wr_error(wr_error), .rd_en(rd_en), .rd_data(rd_data), .rd_full(rd_full),
        .rd_empty(rd_empty), .rd_count(rd_count), .rd_overflow(rd_overflow),
        .rd_error(rd_error)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pop and compare whenever the read FIFO presents a word
    always @(negedge clk) begin
        mon_rd_en = 1'b0;
        if (drain_en && rst_n && !rd_empty) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: got 0x%0h expected no word", rd_data);
            end else begin
                check("rd_data", {32'd0, rd_data}, {32'd0, exp_q.pop_front()});
            end
            mon_rd_en = 1'b1;
        end
    end

    task automatic wr_word(input logic [31:0] d, input logic [3:0] m);
        wr_en = 1'b1; wr_data = d; wr_mask = m;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic issue(input logic [2:0] instr, input logic [5:0] bl, input logic [29:0] addr);
        cmd_en = 1'b1; cmd_instr = instr; cmd_bl = bl; cmd_byte_addr = addr;
        @(negedge clk);
        cmd_en = 1'b0;
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("drain_done", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        settle(3);
    endtask

    task automatic wait_rd_count(input int n);
        int k = 0;
        while (rd_count != 7'(n) && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("rd_count_reach", {57'd0, rd_count}, 64'(n));
    endtask

    initial begin
        rst_n = 1'b0; cmd_en = 1'b0; cmd_instr = 3'd0; cmd_bl = 6'd0; cmd_byte_addr = 30'd0;
        wr_en = 1'b0; wr_mask = 4'd0; wr_data = 32'd0; stim_rd_en = 1'b0; drain_en = 1'b0;
        settle(3);
        check("rst_cmd_empty", {63'd0, cmd_empty}, 64'd1);
        check("rst_wr_empty", {63'd0, wr_empty}, 64'd1);
        check("rst_rd_empty", {63'd0, rd_empty}, 64'd1);
        check("rst_cal", {63'd0, calibration_done}, 64'd0);
        check("rst_wr_count", {57'd0, wr_count}, 64'd0);
        check("rst_rd_data", {32'd0, rd_data}, 64'd0);
        check("rst_flags", {60'd0, wr_underrun, wr_error, rd_overflow, rd_error}, 64'd0);
        check("rst_fulls", {61'd0, cmd_full, wr_full, rd_full}, 64'd0);

        // Calibration, with a REFRESH queued early that must wait
        rst_n = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk);
            if (i == 5) begin
                cmd_en = 1'b1; cmd_instr = I_REF; cmd_bl = 6'd0; cmd_byte_addr = 30'd0;
            end else begin
                cmd_en = 1'b0;
            end
            if (i == 31) begin
                check("cal_at_31", {63'd0, calibration_done}, 64'd0);
                check("cmd_held_31", {63'd0, cmd_empty}, 64'd0);
            end
            if (i == 32) check("cal_at_32", {63'd0, calibration_done}, 64'd1);
        end
        settle(3);
        check("cmd_popped_after_cal", {63'd0, cmd_empty}, 64'd1);
        settle(20);

        // Write four words, then read them back
        wr_word(32'h11111111, 4'h0);
        wr_word(32'h22222222, 4'h0);
        wr_word(32'h33333333, 4'h0);
        wr_word(32'h44444444, 4'h0);
        check("wr_count_4", {57'd0, wr_count}, 64'd4);
        issue(I_WR, 6'd3, 30'h100);
        settle(10);
        check("wr_drained", {63'd0, wr_empty}, 64'd1);
        exp_q.push_back(32'h11111111); exp_q.push_back(32'h22222222);
        exp_q.push_back(32'h33333333); exp_q.push_back(32'h44444444);
        issue(I_RD, 6'd3, 30'h100);
        wait_rd_count(4);
        drain_en = 1'b1;
        wait_drain();
        check("wr_rd_no_flags", {60'd0, wr_underrun, wr_error, rd_overflow, rd_error}, 64'd0);

        // Byte mask over a zeroed word
        wr_word(32'h00000000, 4'h0);
        issue(I_WR, 6'd0, 30'h40);
        settle(6);
        wr_word(32'hAABBCCDD, 4'b0101);
        issue(I_WR, 6'd0, 30'h40);
        settle(6);
        exp_q.push_back(32'hAA00CC00);
        issue(I_RD, 6'd0, 30'h40);
        wait_drain();

        // Burst wraps from the last word to word 0; low byte bits ignored
        wr_word(32'hA1A1A1A1, 4'h0);
        wr_word(32'hA2A2A2A2, 4'h0);
        issue(I_WR, 6'd1, 30'h3FFC);
        settle(6);
        exp_q.push_back(32'hA1A1A1A1); exp_q.push_back(32'hA2A2A2A2);
        issue(I_RD, 6'd1, 30'h3FFF);
        wait_drain();
        exp_q.push_back(32'hA2A2A2A2);
        issue(I_RD, 6'd0, 30'h0);
        wait_drain();

        // Underrun: two words for a four-word burst over known data
        for (int i = 0; i < 4; i++) wr_word(32'hDEAD0000 + 32'(i), 4'h0);
        issue(I_WR, 6'd3, 30'h200);
        settle(8);
        check("pre_underrun_flags", {62'd0, wr_underrun, wr_error}, 64'd0);
        wr_word(32'h55555555, 4'h0);
        wr_word(32'h66666666, 4'h0);
        issue(I_WR, 6'd3, 30'h200);
        settle(8);
        check("wr_underrun", {63'd0, wr_underrun}, 64'd1);
        check("wr_error_underrun", {63'd0, wr_error}, 64'd1);
        exp_q.push_back(32'h55555555); exp_q.push_back(32'h66666666);
        exp_q.push_back(32'hDEAD0002); exp_q.push_back(32'hDEAD0003);
        issue(I_RD, 6'd3, 30'h200);
        wait_drain();
        check("no_overflow_yet", {63'd0, rd_overflow}, 64'd0);

        // Overflow: two 64-word reads with nobody popping
        drain_en = 1'b0;
        settle(2);
        issue(I_RD, 6'd63, 30'h0);
        issue(I_RD, 6'd63, 30'h0);
        wait_rd_count(64);
        settle(80);
        check("rd_count_64", {57'd0, rd_count}, 64'd64);
        check("rd_full", {63'd0, rd_full}, 64'd1);
        check("rd_overflow", {63'd0, rd_overflow}, 64'd1);
        check("rd_error_ovf", {63'd0, rd_error}, 64'd1);

        // Reset in the middle of a READ with a command and a word queued
        wr_word(32'h77777777, 4'h0);
        issue(I_RD, 6'd63, 30'h0);
        issue(I_REF, 6'd0, 30'h0);
        settle(12);
        check("pre_rst_cmd_queued", {63'd0, cmd_empty}, 64'd0);
        check("pre_rst_wr_queued", {57'd0, wr_count}, 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_empties", {61'd0, cmd_empty, wr_empty, rd_empty}, 64'd7);
        check("midrst_counts", {50'd0, wr_count, rd_count}, 64'd0);
        check("midrst_flags", {60'd0, wr_underrun, wr_error, rd_overflow, rd_error}, 64'd0);
        check("midrst_rd_data", {32'd0, rd_data}, 64'd0);
        rst_n = 1'b1;
        settle(2);

        // Pop on an empty read FIFO
        stim_rd_en = 1'b1;
        @(negedge clk);
        stim_rd_en = 1'b0;
        check("rd_error_empty_pop", {63'd0, rd_error}, 64'd1);
        check("rd_overflow_clear", {63'd0, rd_overflow}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
